// File: rtl/dmem_responder.sv
// Data-memory responder: byte-addressed little-endian array behind a
// valid/ready request channel and a fixed-latency response channel.
module dmem_responder #(
    parameter int ADDRESS_WIDTH = 8,
    parameter int DATA_WIDTH    = 32,
    parameter int LATENCY       = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_we,
    input  logic [ADDRESS_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0]    req_wdata,
    input  logic [1:0]               req_size,
    input  logic                     req_unsigned,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [DATA_WIDTH-1:0]    rsp_rdata,
    output logic                     rsp_err,
    output logic                     busy
);

    localparam int DEPTH = 2 ** ADDRESS_WIDTH;
    localparam logic [3:0] CNT_INIT =
        4'(LATENCY > 1 ? LATENCY - 2 : 0);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t     state;
    logic [3:0] cnt;

    logic [7:0] mem [0:DEPTH-1];

    logic                     accept;
    logic                     is_byte;
    logic                     is_half;
    logic                     is_word;
    logic                     bad;
    logic [ADDRESS_WIDTH-1:0] a1;
    logic [ADDRESS_WIDTH-1:0] a2;
    logic [ADDRESS_WIDTH-1:0] a3;
    logic [7:0]               b0;
    logic [7:0]               b1;
    logic [7:0]               b2;
    logic [7:0]               b3;
    logic [DATA_WIDTH-1:0]    load_data;

    assign accept  = req_valid && (state == IDLE);
    assign is_byte = (req_size == 2'b00);
    assign is_half = (req_size == 2'b01);
    assign is_word = (req_size == 2'b10);

    always_comb begin
        bad = 1'b0;
        unique case (1'b1)
            is_byte: bad = 1'b0;
            is_half: bad = req_addr[0];
            is_word: bad = (req_addr[1:0] != 2'b00);
            default: bad = 1'b1;
        endcase
    end

    assign a1 = req_addr + ADDRESS_WIDTH'(1);
    assign a2 = req_addr + ADDRESS_WIDTH'(2);
    assign a3 = req_addr + ADDRESS_WIDTH'(3);
    assign b0 = mem[req_addr];
    assign b1 = mem[a1];
    assign b2 = mem[a2];
    assign b3 = mem[a3];

    // Extension happens before the snapshot so the response register holds final data.
    always_comb begin
        load_data = '0;
        if (!bad) begin
            unique case (1'b1)
                is_byte: begin
                    if (req_unsigned)
                        load_data = {{(DATA_WIDTH-8){1'b0}}, b0};
                    else
                        load_data = {{(DATA_WIDTH-8){b0[7]}}, b0};
                end
                is_half: begin
                    if (req_unsigned)
                        load_data = {{(DATA_WIDTH-16){1'b0}}, b1, b0};
                    else
                        load_data = {{(DATA_WIDTH-16){b1[7]}}, b1, b0};
                end
                is_word: load_data = {b3, b2, b1, b0};
                default: load_data = '0;
            endcase
        end
    end

    // Array has no reset; rst gating blocks a store racing an async reset.
    always_ff @(posedge clk) begin
        if (accept && rst && req_we && !bad) begin
            mem[req_addr] <= req_wdata[7:0];
            if (is_half || is_word)
                mem[a1] <= req_wdata[15:8];
            if (is_word) begin
                mem[a2] <= req_wdata[23:16];
                mem[a3] <= req_wdata[31:24];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (req_valid) begin
                        rsp_err   <= bad;
                        rsp_rdata <= req_we ? '0 : load_data;
                        req_ready <= 1'b0;
                        busy      <= 1'b1;
                        if (LATENCY > 1) begin
                            state <= WAIT;
                            cnt   <= CNT_INIT;
                        end else begin
                            state     <= RESP;
                            rsp_valid <= 1'b1;
                        end
                    end
                end
                WAIT: begin
                    if (cnt == 4'd0) begin
                        state     <= RESP;
                        rsp_valid <= 1'b1;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state     <= IDLE;
                        rsp_valid <= 1'b0;
                        rsp_rdata <= '0;
                        rsp_err   <= 1'b0;
                        req_ready <= 1'b1;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    cnt       <= 4'd0;
                    req_ready <= 1'b1;
                    rsp_valid <= 1'b0;
                    rsp_rdata <= '0;
                    rsp_err   <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: LATENCY=2 main instance and a
// LATENCY=1 instance for back-to-back throughput.
module tb_dmem_responder;

    logic        clk;
    logic        rst;

    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [7:0]  req_addr;
    logic [31:0] req_wdata;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        busy;

    logic        v1;
    logic        rdy1;
    logic        we1;
    logic [7:0]  addr1;
    logic [31:0] wdata1;
    logic [1:0]  size1;
    logic        uns1;
    logic        rv1;
    logic        rr1;
    logic [31:0] rdata1;
    logic        err1;
    logic        busy1;

    int pass_cnt;
    int total_cnt;

    dmem_responder #(.ADDRESS_WIDTH(8), .DATA_WIDTH(32), .LATENCY(2)) u0 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_size(req_size), .req_unsigned(req_unsigned),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy)
    );

    dmem_responder #(.ADDRESS_WIDTH(8), .DATA_WIDTH(32), .LATENCY(1)) u1 (
        .clk(clk), .rst(rst),
        .req_valid(v1), .req_ready(rdy1),
        .req_we(we1), .req_addr(addr1), .req_wdata(wdata1),
        .req_size(size1), .req_unsigned(uns1),
        .rsp_valid(rv1), .rsp_ready(rr1),
        .rsp_rdata(rdata1), .rsp_err(err1), .busy(busy1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_req(input logic we, input logic [7:0] addr,
                          input logic [31:0] wdata, input logic [1:0] size,
                          input logic uns, output logic [31:0] rdata,
                          output logic err, output int lat);
        int n;
        @(negedge clk);
        n = 0;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            total_cnt++;
            $display("FAIL req_ready_timeout addr=%h", addr);
        end
        req_valid    = 1'b1;
        req_we       = we;
        req_addr     = addr;
        req_wdata    = wdata;
        req_size     = size;
        req_unsigned = uns;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        lat = 1;
        n = 0;
        while (!rsp_valid && n < 50) begin
            @(negedge clk);
            lat++;
            n++;
        end
        rdata = rsp_rdata;
        err   = rsp_err;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total_cnt++;
        if (req_ready !== 1'b1) $display("FAIL reset_ready got=%b exp=1", req_ready);
        else pass_cnt++;
        total_cnt++;
        if (rsp_valid !== 1'b0) $display("FAIL reset_valid got=%b exp=0", rsp_valid);
        else pass_cnt++;
        total_cnt++;
        if (rsp_err !== 1'b0) $display("FAIL reset_err got=%b exp=0", rsp_err);
        else pass_cnt++;
        total_cnt++;
        if (rsp_rdata !== 32'h0) $display("FAIL reset_rdata got=%h exp=0", rsp_rdata);
        else pass_cnt++;
        total_cnt++;
        if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy);
        else pass_cnt++;
        rst = 1'b1;
    endtask

    task automatic test_word();
        logic [31:0] d;
        logic        e;
        int          l;
        do_req(1'b1, 8'h10, 32'hDEADBEEF, 2'b10, 1'b0, d, e, l);
        total_cnt++;
        if (l !== 2) $display("FAIL st_word_lat got=%0d exp=2", l);
        else pass_cnt++;
        total_cnt++;
        if (d !== 32'h0 || e !== 1'b0)
            $display("FAIL st_word_rsp got=%h/%b exp=0/0", d, e);
        else pass_cnt++;
        do_req(1'b0, 8'h10, 32'h0, 2'b10, 1'b0, d, e, l);
        total_cnt++;
        if (l !== 2) $display("FAIL ld_word_lat got=%0d exp=2", l);
        else pass_cnt++;
        total_cnt++;
        if (d !== 32'hDEADBEEF || e !== 1'b0)
            $display("FAIL ld_word got=%h/%b exp=deadbeef/0", d, e);
        else pass_cnt++;
    endtask

    task automatic test_extend();
        logic [31:0] d;
        logic        e;
        int          l;
        do_req(1'b0, 8'h13, 32'h0, 2'b00, 1'b0, d, e, l);
        total_cnt++;
        if (d !== 32'hFFFFFFDE) $display("FAIL ld_b13_s got=%h exp=ffffffde", d);
        else pass_cnt++;
        do_req(1'b0, 8'h13, 32'h0, 2'b00, 1'b1, d, e, l);
        total_cnt++;
        if (d !== 32'h000000DE) $display("FAIL ld_b13_u got=%h exp=000000de", d);
        else pass_cnt++;
        do_req(1'b0, 8'h12, 32'h0, 2'b01, 1'b0, d, e, l);
        total_cnt++;
        if (d !== 32'hFFFFDEAD) $display("FAIL ld_h12_s got=%h exp=ffffdead", d);
        else pass_cnt++;
        do_req(1'b0, 8'h10, 32'h0, 2'b01, 1'b1, d, e, l);
        total_cnt++;
        if (d !== 32'h0000BEEF) $display("FAIL ld_h10_u got=%h exp=0000beef", d);
        else pass_cnt++;
        do_req(1'b0, 8'h11, 32'h0, 2'b00, 1'b0, d, e, l);
        total_cnt++;
        if (d !== 32'hFFFFFFBE) $display("FAIL ld_b11_s got=%h exp=ffffffbe", d);
        else pass_cnt++;
        do_req(1'b0, 8'h10, 32'h0, 2'b10, 1'b1, d, e, l);
        total_cnt++;
        if (d !== 32'hDEADBEEF) $display("FAIL ld_w_uns got=%h exp=deadbeef", d);
        else pass_cnt++;
        do_req(1'b1, 8'h15, 32'h00000071, 2'b00, 1'b0, d, e, l);
        do_req(1'b1, 8'h16, 32'h0000F0E2, 2'b01, 1'b0, d, e, l);
        do_req(1'b1, 8'h14, 32'h000000AB, 2'b00, 1'b0, d, e, l);
        do_req(1'b1, 8'h17, 32'h00000033, 2'b00, 1'b0, d, e, l);
        do_req(1'b0, 8'h14, 32'h0, 2'b10, 1'b0, d, e, l);
        total_cnt++;
        if (d !== 32'h33E271AB) $display("FAIL partial_st got=%h exp=33e271ab", d);
        else pass_cnt++;
    endtask

    task automatic test_errors();
        logic [31:0] d;
        logic        e;
        int          l;
        do_req(1'b1, 8'h20, 32'hAABBCCDD, 2'b10, 1'b0, d, e, l);
        do_req(1'b1, 8'h21, 32'h00001234, 2'b01, 1'b0, d, e, l);
        total_cnt++;
        if (e !== 1'b1 || d !== 32'h0 || l !== 2)
            $display("FAIL st_h21_err got=%b/%h/%0d exp=1/0/2", e, d, l);
        else pass_cnt++;
        do_req(1'b0, 8'h20, 32'h0, 2'b10, 1'b0, d, e, l);
        total_cnt++;
        if (d !== 32'hAABBCCDD || e !== 1'b0)
            $display("FAIL arr_unchanged got=%h/%b exp=aabbccdd/0", d, e);
        else pass_cnt++;
        do_req(1'b0, 8'h20, 32'h0, 2'b11, 1'b0, d, e, l);
        total_cnt++;
        if (e !== 1'b1 || d !== 32'h0)
            $display("FAIL size11_err got=%b/%h exp=1/0", e, d);
        else pass_cnt++;
        do_req(1'b0, 8'h22, 32'h0, 2'b10, 1'b0, d, e, l);
        total_cnt++;
        if (e !== 1'b1 || d !== 32'h0)
            $display("FAIL ld_w22_err got=%b/%h exp=1/0", e, d);
        else pass_cnt++;
        do_req(1'b1, 8'h20, 32'h00005555, 2'b11, 1'b0, d, e, l);
        do_req(1'b0, 8'h20, 32'h0, 2'b10, 1'b0, d, e, l);
        total_cnt++;
        if (d !== 32'hAABBCCDD)
            $display("FAIL st11_nowrite got=%h exp=aabbccdd", d);
        else pass_cnt++;
    endtask

    task automatic test_backpressure();
        logic [31:0] d;
        logic        e;
        int          l;
        int          n;
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 8'h10;
        req_size  = 2'b10;
        @(posedge clk);
        @(negedge clk);
        // A store presented while busy and withdrawn must leave no trace.
        req_we    = 1'b1;
        req_wdata = 32'h0BADF00D;
        n = 0;
        while (!rsp_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        for (int i = 0; i < 5; i++) begin
            total_cnt++;
            if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hDEADBEEF ||
                req_ready !== 1'b0 || busy !== 1'b1)
                $display("FAIL hold_%0d got=%b/%h/%b/%b exp=1/deadbeef/0/1",
                         i, rsp_valid, rsp_rdata, req_ready, busy);
            else pass_cnt++;
            @(negedge clk);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        total_cnt++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || busy !== 1'b0)
            $display("FAIL release got=%b/%b/%b exp=0/1/0",
                     rsp_valid, req_ready, busy);
        else pass_cnt++;
        do_req(1'b0, 8'h10, 32'h0, 2'b10, 1'b0, d, e, l);
        total_cnt++;
        if (d !== 32'hDEADBEEF)
            $display("FAIL withdrawn_st got=%h exp=deadbeef", d);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_wait();
        logic [31:0] d;
        logic        e;
        int          l;
        do_req(1'b1, 8'h50, 32'h11111111, 2'b10, 1'b0, d, e, l);
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 8'h40;
        req_wdata = 32'h12345678;
        req_size  = 2'b10;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        #1 rst = 1'b0;
        #1;
        total_cnt++;
        if (rsp_valid !== 1'b0 || busy !== 1'b0 || req_ready !== 1'b1)
            $display("FAIL rst_wait got=%b/%b/%b exp=0/0/1",
                     rsp_valid, busy, req_ready);
        else pass_cnt++;
        @(negedge clk);
        req_valid = 1'b1;
        req_addr  = 8'h50;
        req_wdata = 32'h99999999;
        @(posedge clk);
        @(negedge clk);
        total_cnt++;
        if (rsp_valid !== 1'b0 || busy !== 1'b0)
            $display("FAIL rst_hold got=%b/%b exp=0/0", rsp_valid, busy);
        else pass_cnt++;
        req_valid = 1'b0;
        rst = 1'b1;
        do_req(1'b0, 8'h40, 32'h0, 2'b10, 1'b0, d, e, l);
        total_cnt++;
        if (d !== 32'h12345678 || l !== 2)
            $display("FAIL post_rst_ld got=%h/%0d exp=12345678/2", d, l);
        else pass_cnt++;
        do_req(1'b0, 8'h50, 32'h0, 2'b10, 1'b0, d, e, l);
        total_cnt++;
        if (d !== 32'h11111111)
            $display("FAIL rst_blk_st got=%h exp=11111111", d);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        logic prev;
        int   acc;
        @(negedge clk);
        rr1    = 1'b1;
        v1     = 1'b1;
        we1    = 1'b1;
        addr1  = 8'h30;
        wdata1 = 32'hCAFEF00D;
        size1  = 2'b10;
        uns1   = 1'b0;
        prev   = 1'b0;
        acc    = 0;
        for (int i = 0; i < 8; i++) begin
            if (rdy1) acc++;
            @(negedge clk);
            total_cnt++;
            if (busy1 !== ~prev || rdy1 !== ~busy1 || rv1 !== busy1)
                $display("FAIL b2b_%0d busy got=%b exp=%b rdy=%b rv=%b",
                         i, busy1, ~prev, rdy1, rv1);
            else pass_cnt++;
            prev = busy1;
        end
        total_cnt++;
        if (acc !== 4) $display("FAIL b2b_accepts got=%0d exp=4", acc);
        else pass_cnt++;
        v1 = 1'b0;
        @(negedge clk);
        v1    = 1'b1;
        we1   = 1'b0;
        addr1 = 8'h32;
        size1 = 2'b01;
        uns1  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        v1 = 1'b0;
        total_cnt++;
        if (rv1 !== 1'b1 || rdata1 !== 32'h0000CAFE || err1 !== 1'b0)
            $display("FAIL l1_load got=%b/%h/%b exp=1/0000cafe/0",
                     rv1, rdata1, err1);
        else pass_cnt++;
        @(negedge clk);
        rr1 = 1'b0;
    endtask

    initial begin
        pass_cnt     = 0;
        total_cnt    = 0;
        rst          = 1'b0;
        req_valid    = 1'b0;
        req_we       = 1'b0;
        req_addr     = 8'h0;
        req_wdata    = 32'h0;
        req_size     = 2'b00;
        req_unsigned = 1'b0;
        rsp_ready    = 1'b0;
        v1           = 1'b0;
        we1          = 1'b0;
        addr1        = 8'h0;
        wdata1       = 32'h0;
        size1        = 2'b00;
        uns1         = 1'b0;
        rr1          = 1'b0;
        test_reset();
        test_word();
        test_extend();
        test_errors();
        test_backpressure();
        test_reset_mid_wait();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1);
    end

endmodule
